phys_reg_free_list: RTL and testbench
=====================================

// Module: phys_reg_free_list
// PURPOSE
//  Allocator for the physical register file shared by the rename stage and the ROB commit path.
//  - Circular buffer of free physical register indices.
//  - Rename pops one index per cycle; it becomes the new RAT mapping for rd != x0.
//  - Commit pushes the superseded (old) physical index back.
//  - On flush, all speculatively popped indices are reclaimed in one cycle via a committed-head checkpoint.
// PARAMETERS
//  PHYS_REGS   64  total physical registers; index width PHYS_REG_ADDR = $clog2(PHYS_REGS)
//  ARCH_REGS   32  architectural registers; p0..p(ARCH_REGS-1) hold the reset mapping
//  DEPTH       PHYS_REGS-ARCH_REGS  free-list capacity; must be a power of two
// PORTS
//  clk              in   1              clock, all state updates on posedge
//  rst              in   1              synchronous, active-high reset
//  flush            in   1              mispredict/exception recovery
//  alloc_req        in   1              rename wants a register (rd != x0)
//  alloc_ready      out  1              a free index is available this cycle
//  alloc_phys_addr  out  PHYS_REG_ADDR  index at spec head; valid when alloc_ready
//  commit_en        in   1              ROB retires an instruction that allocated (rd != x0)
//  commit_old_phys  in   PHYS_REG_ADDR  superseded mapping being released
//  free_count       out  $clog2(DEPTH)+1  entries between spec head and tail
//  protocol_err     out  1              sticky error flag
// BEHAVIOUR
//  Storage: fl_mem[DEPTH]. Pointers spec_head, arch_head and tail are each $clog2(DEPTH)+1 bits (MSB = wrap bit).
//  - Index = low bits; pointers wrap modulo 2*DEPTH.
//  Reset:
//  - fl_mem[i] = ARCH_REGS+i; spec_head = arch_head = 0; tail = DEPTH (wrap bit set, list full).
//  - alloc_ready = 1; alloc_phys_addr = ARCH_REGS; free_count = DEPTH; protocol_err = 0.
//  - rst has priority over everything, including flush and any operation in progress.
//  Combinational outputs:
//  - free_count = tail - spec_head.
//  - alloc_ready = (free_count != 0).
//  - alloc_phys_addr = fl_mem[spec_head].
//  - Zero-latency read: alloc fires on the same edge as the request.
//  Alloc (alloc_req && alloc_ready):
//  - spec_head += 1 at the edge.
//  - alloc_req while !alloc_ready: no state change; rename must stall.
//  Commit (commit_en):
//  - fl_mem[tail] <= commit_old_phys; tail += 1; arch_head += 1.
//  - Invariant: tail - arch_head == DEPTH always.
//  Simultaneous alloc and commit:
//  - Both apply; free_count is unchanged.
//  - The pushed entry is not visible on alloc_phys_addr until the next cycle.
//  Flush:
//  - spec_head <= arch_head, plus 1 if commit_en is high in the same cycle.
//  - A commit in the flush cycle is still fully applied. alloc_req is ignored during flush.
//  - Next cycle: free_count == DEPTH.
//  Errors:
//  - Condition: commit_en while arch_head == spec_head and no alloc fires that cycle (commit with nothing in flight).
//  - Response: the commit is dropped, and protocol_err sets and holds until rst.
//  - Pushing p0, or any index < ARCH_REGS, is legal; the list does not check index values.
//  Empty boundary:
//  - When free_count == 0, alloc_ready stays 0 until a commit edge.
// CONFIGURATION
//  FREELIST_BYPASS_EN defined:
//  - When free_count == 0 and commit_en is high: alloc_ready = 1 and alloc_phys_addr = commit_old_phys in the same cycle.
//  - If alloc_req fires, the entry is written and popped on the same edge: tail, spec_head and arch_head all advance.
//  - free_count stays 0.
//  Not defined:
//  - No bypass; the empty list stalls rename for at least one cycle after a commit.
// TESTING
//  T1 rst, then 32 back-to-back allocs:
//  - Indices 32..63 appear in order; after the 32nd, alloc_ready = 0 and free_count = 0.
//  T2 From empty, commit_en with old_phys = 7, then alloc_req:
//  - Next cycle: alloc_ready = 1, alloc_phys_addr = 7, free_count = 1; the alloc returns 7.
//  T3 Alloc 5 regs (32..36), commit 2 (old = 3, 4), then flush:
//  - free_count = 32 next cycle; alloc_phys_addr = 34.
//  - Further pops return 34, 35, 36, ..., 63, 3, 4.
//  T4 Simultaneous alloc and commit every cycle for 100 cycles:
//  - free_count constant at 32; pointer wrap exercised; indices returned in FIFO order.
//  T5 commit_en right after rst (nothing in flight):
//  - protocol_err = 1 and stays set; all pointers unchanged; rst clears it.
//  T6 FREELIST_BYPASS_EN, list empty, commit_en (old = 9) and alloc_req in the same cycle:
//  - alloc_phys_addr = 9 that cycle; free_count stays 0.
//  - Without the macro: alloc_ready = 0 that cycle.

Source files
------------

// File: rtl/phys_reg_free_list_if.sv
// Rename/commit-side bundle for the physical register free list.
// The master side is rename + ROB; the slave side is the free list itself.
interface phys_reg_free_list_if #(
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned ARCH_REGS = 32
);
  localparam int unsigned DEPTH         = PHYS_REGS - ARCH_REGS;
  localparam int unsigned PHYS_REG_ADDR = $clog2(PHYS_REGS);
  localparam int unsigned CNT_W         = $clog2(DEPTH) + 1;

  logic                     flush;
  logic                     alloc_req;
  logic                     alloc_ready;
  logic [PHYS_REG_ADDR-1:0] alloc_phys_addr;
  logic                     commit_en;
  logic [PHYS_REG_ADDR-1:0] commit_old_phys;
  logic [CNT_W-1:0]         free_count;
  logic                     protocol_err;

  modport master (
    output flush,
    output alloc_req,
    output commit_en,
    output commit_old_phys,
    input  alloc_ready,
    input  alloc_phys_addr,
    input  free_count,
    input  protocol_err
  );

  modport slave (
    input  flush,
    input  alloc_req,
    input  commit_en,
    input  commit_old_phys,
    output alloc_ready,
    output alloc_phys_addr,
    output free_count,
    output protocol_err
  );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register indices with a committed-head checkpoint for flush.
// Optional FREELIST_BYPASS_EN forwards a committing index straight to rename when the list is empty.
module phys_reg_free_list #(
  parameter int unsigned PHYS_REGS = 64,
  parameter int unsigned ARCH_REGS = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  phys_reg_free_list_if.slave    fl
);
  localparam int unsigned DEPTH         = PHYS_REGS - ARCH_REGS;
  localparam int unsigned PHYS_REG_ADDR = $clog2(PHYS_REGS);
  localparam int unsigned IDX_W         = $clog2(DEPTH);
  localparam int unsigned PTR_W         = IDX_W + 1;

  typedef logic [PTR_W-1:0]         ptr_t;
  typedef logic [PHYS_REG_ADDR-1:0] preg_t;

  preg_t fl_mem [DEPTH];

  ptr_t spec_head_q, spec_head_d;
  ptr_t arch_head_q, arch_head_d;
  ptr_t tail_q,      tail_d;
  logic protocol_err_q, protocol_err_d;

  ptr_t free_cnt;
  logic list_empty;
  logic bypass;
  logic alloc_fire;
  logic nothing_in_flight;
  logic commit_err;
  logic commit_ok;

  assign free_cnt   = tail_q - spec_head_q;
  assign list_empty = (free_cnt == '0);

`ifdef FREELIST_BYPASS_EN
  assign bypass = list_empty && fl.commit_en;
`else
  assign bypass = 1'b0;
`endif

  assign fl.free_count      = free_cnt;
  assign fl.alloc_ready     = !list_empty || bypass;
  assign fl.alloc_phys_addr = bypass ? fl.commit_old_phys : fl_mem[spec_head_q[IDX_W-1:0]];
  assign fl.protocol_err    = protocol_err_q;

  assign alloc_fire        = fl.alloc_req && fl.alloc_ready && !fl.flush;
  assign nothing_in_flight = (arch_head_q == spec_head_q);
  // A commit that retires the entry popped on the same edge is legitimate.
  assign commit_err        = fl.commit_en && nothing_in_flight && !alloc_fire;
  assign commit_ok         = fl.commit_en && !commit_err;

  always_comb begin
    spec_head_d    = spec_head_q;
    arch_head_d    = arch_head_q;
    tail_d         = tail_q;
    protocol_err_d = protocol_err_q || commit_err;

    if (commit_ok) begin
      arch_head_d = arch_head_q + ptr_t'(1);
      tail_d      = tail_q + ptr_t'(1);
    end

    // Flush rewinds to the committed head, including a commit landing this cycle.
    if (fl.flush) begin
      spec_head_d = arch_head_d;
    end else if (alloc_fire) begin
      spec_head_d = spec_head_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spec_head_q    <= '0;
      arch_head_q    <= '0;
      tail_q         <= ptr_t'(DEPTH);
      protocol_err_q <= 1'b0;
    end else begin
      spec_head_q    <= spec_head_d;
      arch_head_q    <= arch_head_d;
      tail_q         <= tail_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        fl_mem[i] <= preg_t'(int'(ARCH_REGS) + i);
      end
    end else if (commit_ok) begin
      fl_mem[tail_q[IDX_W-1:0]] <= fl.commit_old_phys;
    end
  end

  // Every committed slot is either free or speculatively allocated.
  a_tail_arch_gap: assert property (@(posedge clk) disable iff (rst)
    ptr_t'(tail_q - arch_head_q) == ptr_t'(DEPTH));
  a_free_cnt_range: assert property (@(posedge clk) disable iff (rst)
    int'(free_cnt) <= int'(DEPTH));

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list with a queue-level reference model checked every cycle.
// Build with +define+FREELIST_BYPASS_EN to exercise the empty-list bypass.
module tb_phys_reg_free_list;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
`ifdef FREELIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phys_reg_free_list_if #(.PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS)) fl_if ();

  phys_reg_free_list #(.PHYS_REGS(PHYS_REGS), .ARCH_REGS(ARCH_REGS)) dut (
    .clk (clk),
    .rst (rst),
    .fl  (fl_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: free indices in pop order, and popped-but-uncommitted indices oldest first.
  int free_q[$];
  int infl_q[$];
  bit m_err   = 1'b0;
  bit m_valid = 1'b0;

  task automatic model_step(input bit fl, input bit ar, input bit ce, input int old);
    bit had_infl = (infl_q.size() != 0);
    bit empty    = (free_q.size() == 0);
    bit byp      = BYP && empty && ce;
    bit ready    = !empty || byp;
    bit fire     = ar && ready && !fl;
    if (fire) begin
      if (empty) infl_q.push_back(old);
      else       infl_q.push_back(free_q.pop_front());
    end
    if (ce) begin
      if (!had_infl && !fire) begin
        m_err = 1'b1;
      end else begin
        void'(infl_q.pop_front());
        if (!(fire && empty)) free_q.push_back(old);
      end
    end
    if (fl) begin
      free_q = {infl_q, free_q};
      infl_q.delete();
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      free_q.delete();
      infl_q.delete();
      for (int i = 0; i < DEPTH; i++) free_q.push_back(ARCH_REGS + i);
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      model_step(fl_if.flush, fl_if.alloc_req, fl_if.commit_en, int'(fl_if.commit_old_phys));
    end
  end

  // Compare process: outputs are combinational, so check mid-cycle against model + current inputs.
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      bit e_ready;
      int e_addr;
      e_ready = 1'b0;
      e_addr  = 0;
      if (free_q.size() != 0) begin
        e_ready = 1'b1;
        e_addr  = free_q[0];
      end else if (BYP && fl_if.commit_en) begin
        e_ready = 1'b1;
        e_addr  = int'(fl_if.commit_old_phys);
      end
      check("model_ready", int'(fl_if.alloc_ready), int'(e_ready));
      if (e_ready) check("model_addr", int'(fl_if.alloc_phys_addr), e_addr);
      check("model_count", int'(fl_if.free_count), free_q.size());
      check("model_err", int'(fl_if.protocol_err), int'(m_err));
    end
  end

  task automatic drive(input bit ar, input bit ce, input int old, input bit fl);
    fl_if.alloc_req       = ar;
    fl_if.commit_en       = ce;
    fl_if.commit_old_phys = 6'(old);
    fl_if.flush           = fl;
  endtask

  // Apply inputs for one cycle and stop mid-cycle so literal checks can follow.
  task automatic cyc(input bit ar, input bit ce, input int old, input bit fl);
    drive(ar, ce, old, fl);
    @(negedge clk);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int seq[$];
    int olds[100];
    int e;

    // T1: reset state, then drain the list in order
    do_reset();
    cyc(0, 0, 0, 0);
    check("rst_ready", int'(fl_if.alloc_ready), 1);
    check("rst_addr", int'(fl_if.alloc_phys_addr), 32);
    check("rst_count", int'(fl_if.free_count), 32);
    check("rst_err", int'(fl_if.protocol_err), 0);
    step();
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 0, 0);
      check("t1_addr", int'(fl_if.alloc_phys_addr), 32 + i);
      step();
    end
    cyc(0, 0, 0, 0);
    check("t1_empty_ready", int'(fl_if.alloc_ready), 0);
    check("t1_empty_count", int'(fl_if.free_count), 0);
    step();
    cyc(1, 0, 0, 0);
    step();
    cyc(0, 0, 0, 0);
    check("t1_stall_count", int'(fl_if.free_count), 0);
    step();

    // T2: commit into an empty list, then allocate the returned index
    cyc(0, 1, 7, 0);
    if (!BYP) check("t2_commit_ready", int'(fl_if.alloc_ready), 0);
    step();
    cyc(1, 0, 0, 0);
    check("t2_ready", int'(fl_if.alloc_ready), 1);
    check("t2_addr", int'(fl_if.alloc_phys_addr), 7);
    check("t2_count", int'(fl_if.free_count), 1);
    step();
    cyc(0, 0, 0, 0);
    check("t2_after_count", int'(fl_if.free_count), 0);
    step();

    // T3: 5 allocs, 2 commits, flush reclaims the 3 speculative indices
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0);
      step();
    end
    cyc(0, 1, 3, 0);
    step();
    cyc(0, 1, 4, 0);
    step();
    cyc(0, 0, 0, 1);
    step();
    for (int i = 34; i < 64; i++) seq.push_back(i);
    seq.push_back(3);
    seq.push_back(4);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 0, 0);
      if (i == 0) check("t3_flush_count", int'(fl_if.free_count), 32);
      check("t3_pop", int'(fl_if.alloc_phys_addr), seq[i]);
      step();
    end
    cyc(0, 0, 0, 0);
    check("t3_end_count", int'(fl_if.free_count), 0);
    step();

    // Flush with a same-cycle commit and an ignored alloc_req
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      step();
    end
    cyc(1, 1, 10, 1);
    step();
    cyc(0, 0, 0, 0);
    check("fc_count", int'(fl_if.free_count), 32);
    check("fc_addr", int'(fl_if.alloc_phys_addr), 33);
    step();

    // T4: alloc + commit every cycle, pointers wrap, FIFO order holds
    do_reset();
    for (int i = 0; i < 100; i++) begin
      olds[i] = (i * 7 + 1) % 64;
      cyc(1, 1, olds[i], 0);
      check("t4_count", int'(fl_if.free_count), 32);
      e = (i < 32) ? 32 + i : olds[i - 32];
      check("t4_addr", int'(fl_if.alloc_phys_addr), e);
      step();
    end

    // T5: commit with nothing in flight is dropped and flagged
    do_reset();
    cyc(0, 1, 5, 0);
    step();
    cyc(0, 0, 0, 0);
    check("t5_err", int'(fl_if.protocol_err), 1);
    check("t5_count", int'(fl_if.free_count), 32);
    check("t5_addr", int'(fl_if.alloc_phys_addr), 32);
    step();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0);
      step();
    end
    cyc(1, 0, 0, 0);
    check("t5_err_sticky", int'(fl_if.protocol_err), 1);
    check("t5_alloc_addr", int'(fl_if.alloc_phys_addr), 32);
    step();
    cyc(0, 0, 0, 0);
    check("t5_next_addr", int'(fl_if.alloc_phys_addr), 33);
    check("t5_next_count", int'(fl_if.free_count), 31);
    step();
    do_reset();
    cyc(0, 0, 0, 0);
    check("t5_err_cleared", int'(fl_if.protocol_err), 0);
    step();

    // T6: empty list, commit and alloc on the same edge
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 0, 0);
      step();
    end
    cyc(1, 1, 9, 0);
    if (BYP) begin
      check("t6_byp_ready", int'(fl_if.alloc_ready), 1);
      check("t6_byp_addr", int'(fl_if.alloc_phys_addr), 9);
    end else begin
      check("t6_nobyp_ready", int'(fl_if.alloc_ready), 0);
    end
    check("t6_count", int'(fl_if.free_count), 0);
    step();
    cyc(0, 0, 0, 0);
    if (BYP) begin
      check("t6_byp_after_count", int'(fl_if.free_count), 0);
    end else begin
      check("t6_nobyp_after_count", int'(fl_if.free_count), 1);
      check("t6_nobyp_after_addr", int'(fl_if.alloc_phys_addr), 9);
    end
    check("t6_err", int'(fl_if.protocol_err), 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
